// File: rtl/cam_init_pkg.sv
// cam_init_pkg: state codes, table entry layout and ms timing helpers for cam_init_sequencer
package cam_init_pkg;
  typedef logic [3:0] state_t;
  localparam state_t S_IDLE = 4'd0, S_PWR_DOWN = 4'd1, S_PWR_UP = 4'd2, S_BOOT = 4'd3,
    S_FETCH = 4'd4, S_FETCH_WAIT = 4'd5, S_DECODE = 4'd6, S_ISSUE = 4'd7, S_WAIT_DONE = 4'd8,
    S_DELAY = 4'd9, S_NEXT = 4'd10, S_FINISH = 4'd11, S_FAIL = 4'd12;
  typedef struct packed {
    logic [15:0] reg_addr;
    logic [7:0]  data;
  } entry_t;
  localparam logic [15:0] REG_END = 16'hFFFE;
  localparam logic [15:0] REG_DELAY = 16'hFFFF;
  function automatic logic [31:0] ms_to_cycles(input logic [31:0] clk_hz, input logic [31:0] ms);
    return 32'(64'(clk_hz / 1000) * 64'(ms));
  endfunction
  // a state lasting N cycles loads N-1; zero-length states still last one cycle
  function automatic logic [31:0] load_val(input logic [31:0] cycles);
    return cycles == '0 ? '0 : cycles - 1;
  endfunction
endpackage

// File: rtl/ms_timer.sv
// ms_timer: shared 32-bit down-counter; expired while the count sits at zero
module ms_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value,
  output logic        expired
);
  logic [31:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - 1;
  assign expired = cnt == '0;
endmodule

// File: rtl/cam_init_sequencer.sv
// cam_init_sequencer: OV5640 power-up sequencing followed by a table-driven SCCB register load
module cam_init_sequencer
  import cam_init_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned T_PWDN_MS = 5,
  parameter int unsigned T_RST_MS  = 2,
  parameter int unsigned T_BOOT_MS = 20,
  parameter int unsigned ROM_DEPTH = 256,
  parameter int unsigned AW        = $clog2(ROM_DEPTH),
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic          CLOCK_50,
  input  logic          RESET,
  input  logic          start,
  output logic          cam_pwdn,
  output logic          cam_rst_n,
  output logic [AW-1:0] rom_addr,
  input  logic [23:0]   rom_data,
  output logic          sccb_valid,
  input  logic          sccb_ready,
  output logic [15:0]   sccb_reg,
  output logic [7:0]    sccb_wdata,
  input  logic          sccb_done,
  input  logic          sccb_nack,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] err_index
);
  localparam int unsigned RW = $clog2(RETRY_MAX + 2);
  localparam logic [AW-1:0] LAST = AW'(ROM_DEPTH - 1);
  localparam logic [31:0] LD_PWDN = load_val(ms_to_cycles(CLK_HZ, T_PWDN_MS));
  localparam logic [31:0] LD_RST = load_val(ms_to_cycles(CLK_HZ, T_RST_MS));
  localparam logic [31:0] LD_BOOT = load_val(ms_to_cycles(CLK_HZ, T_BOOT_MS));
  if (64'(CLK_HZ / 1000) * 64'd255 > 64'hFFFF_FFFF) begin : g_width_check
    $error("cam_init_sequencer: a 255 ms delay does not fit the 32-bit cycle counter");
  end
  state_t        state;
  entry_t        entry;
  logic [RW-1:0] retry;
  logic          t_load, expired;
  logic [31:0]   t_val;
  // the timer is loaded on the transition into each timed state
  always_comb begin
    t_load = (state == S_IDLE && start) || (state == S_PWR_DOWN && expired) ||
             (state == S_PWR_UP && expired) || (state == S_DECODE && entry.reg_addr == REG_DELAY);
    t_val = state == S_IDLE ? LD_PWDN : state == S_PWR_DOWN ? LD_RST : state == S_PWR_UP ? LD_BOOT :
            load_val(ms_to_cycles(CLK_HZ, 32'(entry.data)));
  end
  ms_timer u_timer (.clk(CLOCK_50), .rst(RESET), .load(t_load), .value(t_val), .expired(expired));
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= S_IDLE;
      cam_pwdn <= 1'b1;
      cam_rst_n <= 1'b0;
      sccb_valid <= 1'b0;
      sccb_reg <= '0;
      sccb_wdata <= '0;
      rom_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      err_index <= '0;
      entry <= '0;
      retry <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_PWR_DOWN;
          busy <= 1'b1;
          done <= 1'b0;
          error <= 1'b0;
          cam_pwdn <= 1'b1;
          cam_rst_n <= 1'b0;
        end
        S_PWR_DOWN: if (expired) begin
          state <= S_PWR_UP;
          cam_pwdn <= 1'b0;
        end
        S_PWR_UP: if (expired) begin
          state <= S_BOOT;
          cam_rst_n <= 1'b1;
          rom_addr <= '0;
        end
        S_BOOT: if (expired) state <= S_FETCH;
        S_FETCH: state <= S_FETCH_WAIT;
        S_FETCH_WAIT: begin
          entry <= entry_t'(rom_data);
          state <= S_DECODE;
        end
        S_DECODE:
          if (entry.reg_addr == REG_END) state <= S_FINISH;
          else if (entry.reg_addr == REG_DELAY) state <= S_DELAY;
          else begin
            state <= S_ISSUE;
            retry <= '0;
            sccb_valid <= 1'b1;
            sccb_reg <= entry.reg_addr;
            sccb_wdata <= entry.data;
          end
        S_ISSUE: if (sccb_ready) begin
          sccb_valid <= 1'b0;
          state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: if (sccb_done) begin
          if (!sccb_nack) state <= S_NEXT;
          else if (int'(retry) < int'(RETRY_MAX)) begin
            retry <= retry + 1'b1;
            sccb_valid <= 1'b1;
            state <= S_ISSUE;
          end else begin
            err_index <= rom_addr;
            state <= S_FAIL;
          end
        end
        S_DELAY: if (expired) state <= S_NEXT;
        S_NEXT:
          if (rom_addr == LAST) state <= S_FINISH;
          else begin
            rom_addr <= rom_addr + 1'b1;
            state <= S_FETCH;
          end
        S_FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= S_IDLE;
        end
        S_FAIL: begin
          error <= 1'b1;
          busy <= 1'b0;
          cam_pwdn <= 1'b1;
          cam_rst_n <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cam_init_sequencer.sv
// tb_cam_init_sequencer: randomized scoreboard bench with a table-walking reference model
module tb_cam_init_sequencer;
  localparam int CLK_HZ = 10_000, ROM_DEPTH = 4, AW = 2, RETRY_MAX = 3, CPM = CLK_HZ / 1000;
  localparam int G_START = 1 + CPM * (5 + 2 + 20) + 3;
  localparam int G_NEXT = 5, G_RETRY = 1, T_PWDN_FALL = 1 + CPM * 5, T_RSTN_RISE = 1 + CPM * 7;
  logic clk = 0, RESET = 1, start = 0;
  logic cam_pwdn, cam_rst_n, sccb_valid, sccb_ready = 0, sccb_done = 0, sccb_nack = 0;
  logic busy, done, error;
  logic [AW-1:0] rom_addr, err_index;
  logic [23:0] rom_data;
  logic [15:0] sccb_reg;
  logic [7:0] sccb_wdata;
  logic [23:0] rom [ROM_DEPTH];
  logic [23:0] tbl [ROM_DEPTH];
  int nk [ROM_DEPTH];
  logic [15:0] wreg_q[$];
  logic [7:0] wdat_q[$];
  int wgap_q[$];
  bit nack_q[$];
  logic [2:0] out_q[$];
  int checks = 0, errors = 0, cyc = 0, evt = 0, evt_start = 0, stall = 4;
  bit hs = 0, pend = 0, flush = 0;

  cam_init_sequencer #(.CLK_HZ(CLK_HZ), .ROM_DEPTH(ROM_DEPTH)) dut (
    .CLOCK_50(clk), .RESET(RESET), .start(start), .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n),
    .rom_addr(rom_addr), .rom_data(rom_data), .sccb_valid(sccb_valid), .sccb_ready(sccb_ready),
    .sccb_reg(sccb_reg), .sccb_wdata(sccb_wdata), .sccb_done(sccb_done), .sccb_nack(sccb_nack),
    .busy(busy), .done(done), .error(error), .err_index(err_index));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: walk the table by the sequencing rules, producing the writes (with the cycle gap
  // from the previous start/completion to each request) and the final outcome.
  task automatic model();
    int gap = G_START;
    for (int i = 0; i < ROM_DEPTH; i++) begin
      logic [15:0] a = tbl[i][23:8];
      logic [7:0] d = tbl[i][7:0];
      if (a == 16'hFFFE) begin
        out_q.push_back(3'b000);
        return;
      end
      if (a == 16'hFFFF) gap += (CPM * d > 0 ? CPM * d : 1) + 4;
      else for (int att = 0; att <= RETRY_MAX; att++) begin
        wreg_q.push_back(a);
        wdat_q.push_back(d);
        wgap_q.push_back(gap);
        nack_q.push_back(att < nk[i]);
        if (att >= nk[i]) begin
          gap = G_NEXT;
          break;
        end
        if (att == RETRY_MAX) begin
          out_q.push_back({1'b1, 2'(i)});
          return;
        end
        gap = G_RETRY;
      end
    end
    out_q.push_back(3'b000);
  endtask

  task automatic clear_queues();
    wreg_q.delete(); wdat_q.delete(); wgap_q.delete(); nack_q.delete(); out_q.delete();
  endtask

  task automatic check_reset();
    chk("rst_pwdn", cam_pwdn, 1); chk("rst_rstn", cam_rst_n, 0); chk("rst_valid", sccb_valid, 0);
    chk("rst_reg", sccb_reg, 0); chk("rst_wdata", sccb_wdata, 0); chk("rst_addr", rom_addr, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_error", error, 0);
    chk("rst_err_index", err_index, 0);
  endtask

  task automatic launch();
    for (int i = 0; i < ROM_DEPTH; i++) rom[i] = tbl[i];
    model();
    stall = 4;
    @(posedge clk); #1 start = 1; evt = cyc; evt_start = cyc;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic run_seq(input bit dup);
    int t = 0;
    launch();
    while (out_q.size() != 0 && t < 5000) begin
      @(posedge clk); #1 t++;
      start = dup && t == 100;
    end
    start = 0;
    chk("outcome_seen", out_q.size() == 0, 1);
    chk("writes_left", wreg_q.size(), 0);
    clear_queues();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // SCCB master model: random ready stalls, random completion latency, spurious done while unaccepted
  initial begin : master
    int lat = 0;
    bit nf = 0;
    forever begin
      @(posedge clk); #1 sccb_done = 0; sccb_nack = 0;
      if (flush) begin
        pend = 0; sccb_ready = 0; flush = 0;
      end else if (hs) begin
        sccb_ready = 0; pend = 1; lat = $urandom_range(1, 6); stall = $urandom_range(0, 3);
        nf = nack_q.size() != 0 ? nack_q.pop_front() : 1'b0;
      end else if (pend) begin
        lat--;
        if (lat == 0) begin
          sccb_done = 1; sccb_nack = nf; pend = 0; evt = cyc;
        end
      end else if (sccb_valid) begin
        if (stall == 0) sccb_ready = 1;
        else begin
          stall--;
          if ($urandom_range(0, 3) == 0) begin
            sccb_done = 1; sccb_nack = 1'($urandom_range(0, 1));
          end
        end
      end
    end
  end

  initial begin : monitor
    logic pv = 0, pr = 0, pdone = 0, perr = 0, ppw = 1, prn = 0;
    logic [23:0] pw = 0;
    int rgap = 0;
    logic [2:0] o;
    forever begin
      @(negedge clk);
      hs = sccb_valid && sccb_ready && !RESET;
      if (!RESET) begin
        if (sccb_valid && !pv) rgap = cyc - evt;
        if (pv && !pr) begin
          chk("valid_held", sccb_valid, 1);
          chk("req_stable", {sccb_reg, sccb_wdata}, pw);
        end
        if (sccb_valid && sccb_ready) begin
          if (wreg_q.size() == 0) chk("unexpected_write", {sccb_reg, sccb_wdata}, 32'hFFFFFFFF);
          else begin
            chk("write_reg", sccb_reg, wreg_q.pop_front());
            chk("write_data", sccb_wdata, wdat_q.pop_front());
            chk("write_gap", rgap, wgap_q.pop_front());
          end
        end
        if (ppw && !cam_pwdn) chk("pwdn_release", cyc - evt_start, T_PWDN_FALL);
        if (!prn && cam_rst_n) chk("rstn_release", cyc - evt_start, T_RSTN_RISE);
        if ((done && !pdone) || (error && !perr)) begin
          if (out_q.size() == 0) chk("unexpected_end", {done, error}, 0);
          else begin
            o = out_q.pop_front();
            chk("end_done", done, !o[2]); chk("end_error", error, o[2]); chk("end_busy", busy, 0);
            chk("end_pwdn", cam_pwdn, o[2]); chk("end_rstn", cam_rst_n, !o[2]);
            if (o[2]) chk("err_index", err_index, o[1:0]);
          end
        end
      end
      pv = sccb_valid; pr = sccb_ready; pw = {sccb_reg, sccb_wdata};
      pdone = done; perr = error; ppw = cam_pwdn; prn = cam_rst_n;
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int t;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk); #1 RESET = 0;
    repeat (2) @(posedge clk);
    #1;
    tbl = '{24'h300882, 24'hFFFF03, 24'h310311, 24'hFFFE00};
    nk = '{0, 0, 0, 0};
    run_seq(1);
    nk = '{0, 0, 3, 0};
    run_seq(0);
    nk = '{0, 0, 4, 0};
    run_seq(0);
    nk = '{0, 0, 0, 0};
    run_seq(0);
    tbl = '{24'h3008A1, 24'h3017FF, 24'h4300F3, 24'h503D80};
    nk = '{1, 0, 2, 0};
    run_seq(1);
    // reset while a transfer is waiting for completion
    tbl = '{24'h300882, 24'h310311, 24'h3103AA, 24'hFFFE00};
    nk = '{0, 0, 0, 0};
    launch();
    t = 0;
    while (!pend && t < 2000) begin
      @(posedge clk); #1 t++;
    end
    chk("reached_wait_done", pend, 1);
    RESET = 1; flush = 1;
    @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk); #1 RESET = 0;
    clear_queues();
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < ROM_DEPTH; i++) begin
        int r = $urandom_range(0, 9);
        logic [15:0] a = 16'($urandom);
        if (a >= 16'hFFFE) a = 16'h3000;
        tbl[i] = r < 2 ? {16'hFFFF, 8'($urandom_range(0, 3))} :
                 (r == 2 && i > 0) ? 24'hFFFE00 : {a, 8'($urandom)};
        nk[i] = $urandom_range(0, 9) < 6 ? 0 : $urandom_range(1, 4);
      end
      run_seq(n[0]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
